// File: rtl/div8_seq_ctrl.sv
// Restoring 8-bit divider controller that steps an external ripple subtractor once per clock.
// Optional build macro DIV8_SIGNED_EN selects two's-complement operands and signed results.
module div8_seq_ctrl (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       DivByZero,
  output logic [7:0] SubA,
  output logic [7:0] SubB,
  output logic       SubCin,
  input  logic [7:0] SubS,
  input  logic       SubCout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] rem_r, quo_r, div_r;
  logic [2:0] cnt_r;
  logic       accept_s;
  logic [7:0] rem_next_s, quo_next_s;
  logic [7:0] dividend_mag_s, divisor_mag_s;
  logic [7:0] quo_res_s, rem_res_s;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    neg8 = (~v) + 8'd1;
  endfunction

`ifdef DIV8_SIGNED_EN
  logic q_neg_r, r_neg_r;

  assign dividend_mag_s = Dividend[7] ? neg8(Dividend) : Dividend;
  assign divisor_mag_s  = Divisor[7]  ? neg8(Divisor)  : Divisor;
  assign quo_res_s      = q_neg_r ? neg8(quo_next_s) : quo_next_s;
  assign rem_res_s      = r_neg_r ? neg8(rem_next_s) : rem_next_s;

  // Operand signs captured at acceptance drive the final result correction.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (state_r == IDLE && Start) begin
      q_neg_r <= Dividend[7] ^ Divisor[7];
      r_neg_r <= Dividend[7];
    end
  end
`else
  assign dividend_mag_s = Dividend;
  assign divisor_mag_s  = Divisor;
  assign quo_res_s      = quo_next_s;
  assign rem_res_s      = rem_next_s;
`endif

  assign Busy   = (state_r != IDLE);
  assign Done   = (state_r == DONE);
  assign SubCin = 1'b0;

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, subtractor operands and one trial step of the restoring division.
  always_comb begin
    state_s    = state_r;
    SubA       = 8'd0;
    SubB       = 8'd0;
    accept_s   = 1'b0;
    rem_next_s = rem_r;
    quo_next_s = quo_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          if (Divisor == 8'd0) begin
            state_s = DONE;
          end else begin
            state_s = ITER;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        SubA = {rem_r[6:0], quo_r[7]};
        SubB = div_r;
        // A set R[7] means the 9-bit trial already exceeds any divisor.
        accept_s = rem_r[7] | ~SubCout;
        if (accept_s) begin
          rem_next_s = SubS;
          quo_next_s = {quo_r[6:0], 1'b1};
        end else begin
          rem_next_s = {rem_r[6:0], quo_r[7]};
          quo_next_s = {quo_r[6:0], 1'b0};
        end
        if (cnt_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = ITER;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Working registers and held results.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rem_r     <= 8'd0;
      quo_r     <= 8'd0;
      div_r     <= 8'd0;
      cnt_r     <= 3'd0;
      Quotient  <= 8'd0;
      Remainder <= 8'd0;
      DivByZero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start && Divisor != 8'd0) begin
            rem_r <= 8'd0;
            quo_r <= dividend_mag_s;
            div_r <= divisor_mag_s;
            cnt_r <= 3'd0;
          end else if (Start) begin
            Quotient  <= 8'hFF;
            Remainder <= Dividend;
            DivByZero <= 1'b1;
          end
        end
        ITER: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            Quotient  <= quo_res_s;
            Remainder <= rem_res_s;
            DivByZero <= 1'b0;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
